// File: rtl/glb2lb_pkg.sv
// Shared types for the GLB -> LB tile mover: one-hot FSM encoding and
// the width rule for the element counters.
package glb2lb_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        ISSUE = 4'b0010,
        DRAIN = 4'b0100,
        DONE  = 4'b1000
    } state_e;

    // Wide enough for (63+6)*(63+6) padded elements without overflow.
    function automatic int cnt_wid(input int dim_wid);
        return 2 * dim_wid + 2;
    endfunction

endpackage

// File: rtl/glb_2_lb_dma_if.sv
// Control, GLB read-port and LB write-port signals of the tile mover.
// master = the DMA engine, slave = scheduler plus SRAM side.
interface glb_2_lb_dma_if #(
    parameter int RD_ADDR_WID = 16,
    parameter int WR_ADDR_WID = 10,
    parameter int DATA_WID    = 128,
    parameter int DIM_WID     = 6
);
    logic                   start;
    logic                   abort;
    logic                   busy;
    logic                   done;
    logic                   aborted;
    logic [RD_ADDR_WID-1:0] src_base;
    logic [RD_ADDR_WID-1:0] src_stride;
    logic [WR_ADDR_WID-1:0] dst_base;
    logic [DIM_WID-1:0]     length;
    logic [DIM_WID-1:0]     height;
    logic [1:0]             pad;
    logic                   rd_en;
    logic [RD_ADDR_WID-1:0] rd_addr;
    logic [DATA_WID-1:0]    rd_data;
    logic                   wr_en;
    logic [WR_ADDR_WID-1:0] wr_addr;
    logic [DATA_WID-1:0]    wr_data;

    modport master (
        input  start, abort, src_base, src_stride, dst_base, length, height, pad, rd_data,
        output busy, done, aborted, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );

    modport slave (
        output start, abort, src_base, src_stride, dst_base, length, height, pad, rd_data,
        input  busy, done, aborted, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/glb2lb_lat_pipe.sv
// Delay line matching the GLB read latency; each stage carries
// {valid, is_pad, wr_addr} for one issued element.
module glb2lb_lat_pipe #(
    parameter int DEPTH    = 2,
    parameter int ADDR_WID = 10
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic                in_pad,
    input  logic [ADDR_WID-1:0] in_addr,
    output logic                out_valid,
    output logic                out_pad,
    output logic [ADDR_WID-1:0] out_addr
);
    localparam int SW = ADDR_WID + 2;

    logic [SW-1:0] stage_reg  [DEPTH];
    logic [SW-1:0] stage_next [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign stage_next[gi] = {in_valid, in_pad, in_addr};
            end else begin : g_link
                assign stage_next[gi] = stage_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) stage_reg[i] <= stage_next[i];
        end
    end

    assign {out_valid, out_pad, out_addr} = stage_reg[DEPTH-1];

endmodule

// File: rtl/glb_2_lb_dma.sv
// 2-D tile mover GLB -> LB: strided reads, dense row-major writes.
// Optional zero border enabled by defining GLB2LB_PAD_EN.
module glb_2_lb_dma
    import glb2lb_pkg::*;
#(
    parameter int RD_ADDR_WID = 16,
    parameter int WR_ADDR_WID = 10,
    parameter int DATA_WID    = 128,
    parameter int DIM_WID     = 6,
    parameter int RD_LAT      = 2
) (
    input logic            clock,
    input logic            rst_n,
    glb_2_lb_dma_if.master bus
);
    localparam int CNT_WID = cnt_wid(DIM_WID);
    localparam int EXT_WID = DIM_WID + 1;
    localparam int DRN_WID = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_e                 state_reg, state_next;
    logic [1:0]             pad_in, pad_reg;
    logic [DIM_WID-1:0]     len_reg, hgt_reg;
    logic [EXT_WID-1:0]     cols_in, rows_in, cols_reg, col_reg, row_reg;
    logic [RD_ADDR_WID-1:0] stride_reg, row_addr_reg, origin_in;
    logic [WR_ADDR_WID-1:0] dst_reg, slot_addr, pipe_addr;
    logic [CNT_WID-1:0]     idx_reg, total_reg, total_in;
    logic [DRN_WID-1:0]     drain_reg;
    logic                   aborted_reg;
    logic                   is_border, last_col, last_elem, empty_in, issue;
    logic                   pipe_valid, pipe_pad;

`ifdef GLB2LB_PAD_EN
    assign pad_in = bus.pad;
`else
    logic pad_unused;
    assign pad_in     = 2'd0;
    assign pad_unused = ^bus.pad;
`endif

    assign cols_in   = EXT_WID'(bus.length) + EXT_WID'({pad_in, 1'b0});
    assign rows_in   = EXT_WID'(bus.height) + EXT_WID'({pad_in, 1'b0});
    assign total_in  = CNT_WID'(cols_in) * CNT_WID'(rows_in);
    assign empty_in  = (bus.length == '0) || (bus.height == '0);
    // Bias the origin back by p rows and p columns so interior (p,p) hits src_base.
    assign origin_in = bus.src_base - (bus.src_stride * RD_ADDR_WID'(pad_in))
                       - RD_ADDR_WID'(pad_in);

    assign is_border = (col_reg < EXT_WID'(pad_reg)) || (row_reg < EXT_WID'(pad_reg))
                    || (col_reg >= EXT_WID'(len_reg) + EXT_WID'(pad_reg))
                    || (row_reg >= EXT_WID'(hgt_reg) + EXT_WID'(pad_reg));
    assign last_col  = (col_reg == cols_reg - EXT_WID'(1));
    assign last_elem = (idx_reg == total_reg - CNT_WID'(1));
    assign issue     = (state_reg == ISSUE);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = empty_in ? DONE : ISSUE;
            ISSUE:   if (bus.abort || last_elem) state_next = DRAIN;
            DRAIN:   if (drain_reg == DRN_WID'(RD_LAT - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            pad_reg      <= '0;
            len_reg      <= '0;
            hgt_reg      <= '0;
            cols_reg     <= '0;
            col_reg      <= '0;
            row_reg      <= '0;
            stride_reg   <= '0;
            row_addr_reg <= '0;
            dst_reg      <= '0;
            idx_reg      <= '0;
            total_reg    <= '0;
            drain_reg    <= '0;
            aborted_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            drain_reg <= (state_reg == DRAIN) ? drain_reg + DRN_WID'(1) : '0;
            if (state_reg == IDLE && bus.start) begin
                pad_reg      <= pad_in;
                len_reg      <= bus.length;
                hgt_reg      <= bus.height;
                cols_reg     <= cols_in;
                stride_reg   <= bus.src_stride;
                row_addr_reg <= origin_in;
                dst_reg      <= bus.dst_base;
                total_reg    <= total_in;
                col_reg      <= '0;
                row_reg      <= '0;
                idx_reg      <= '0;
                aborted_reg  <= 1'b0;
            end else if (issue) begin
                idx_reg <= idx_reg + CNT_WID'(1);
                if (last_col) begin
                    col_reg      <= '0;
                    row_reg      <= row_reg + EXT_WID'(1);
                    row_addr_reg <= row_addr_reg + stride_reg;
                end else begin
                    col_reg <= col_reg + EXT_WID'(1);
                end
                if (bus.abort) aborted_reg <= 1'b1;
            end
        end
    end

    assign slot_addr = dst_reg + idx_reg[WR_ADDR_WID-1:0];

    glb2lb_lat_pipe #(
        .DEPTH    (RD_LAT),
        .ADDR_WID (WR_ADDR_WID)
    ) u_lat_pipe (
        .clock     (clock),
        .rst_n     (rst_n),
        .in_valid  (issue),
        .in_pad    (is_border),
        .in_addr   (slot_addr),
        .out_valid (pipe_valid),
        .out_pad   (pipe_pad),
        .out_addr  (pipe_addr)
    );

    assign bus.busy    = (state_reg == ISSUE) || (state_reg == DRAIN);
    assign bus.done    = (state_reg == DONE);
    assign bus.aborted = (state_reg == DONE) && aborted_reg;
    assign bus.rd_en   = issue && !is_border;
    assign bus.rd_addr = row_addr_reg + RD_ADDR_WID'(col_reg);
    assign bus.wr_en   = pipe_valid;
    assign bus.wr_addr = pipe_addr;
    assign bus.wr_data = pipe_pad ? '0 : bus.rd_data;

endmodule

// File: tb/tb_glb_2_lb_dma.sv
// Directed bench for glb_2_lb_dma: GLB model returns {TAG, addr} RD_LAT
// cycles after each read, every write is logged and compared afterwards.
module tb_glb_2_lb_dma;
    localparam logic [111:0] TAG = 112'h1234_5678_9ABC_DEF0_1122_3344_5566;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    glb_2_lb_dma_if bus_if ();
    glb_2_lb_dma dut (.clock(clock), .rst_n(rst_n), .bus(bus_if));

    int n_checks = 0;
    int n_err    = 0;

    // GLB model with a two-cycle read latency
    logic [1:0]  rdv  = '0;
    logic [15:0] rda0 = '0;
    logic [15:0] rda1 = '0;
    always @(posedge clock) begin
        rdv  <= {rdv[0], bus_if.rd_en === 1'b1};
        rda1 <= rda0;
        rda0 <= bus_if.rd_addr;
    end

    function automatic logic [127:0] data_of(input logic [15:0] a);
        return {TAG, a};
    endfunction

    assign bus_if.rd_data = rdv[1] ? data_of(rda1) : '1;

    logic [15:0]  rd_q[$];
    int           rk_q[$];
    logic [9:0]   wa_q[$];
    logic [127:0] wd_q[$];
    int           wk_q[$];
    int n_done, done_k, ab_at_done, busy_hi, busy_after, rd_after;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic run_xfer(input logic [15:0] base, input logic [15:0] stride,
                            input logic [9:0] dst, input logic [5:0] len, input logic [5:0] hgt,
                            input logic [1:0] pd, input int abort_at, input bit restart);
        int tail;
        rd_q.delete(); rk_q.delete(); wa_q.delete(); wd_q.delete(); wk_q.delete();
        n_done = 0; done_k = -1; ab_at_done = 0; busy_hi = 0; busy_after = 0; rd_after = 0;
        tail = 0;
        @(negedge clock);
        bus_if.src_base   = base;
        bus_if.src_stride = stride;
        bus_if.dst_base   = dst;
        bus_if.length     = len;
        bus_if.height     = hgt;
        bus_if.pad        = pd;
        bus_if.start      = 1'b1;
        @(posedge clock);
        // k counts cycles after the edge that sampled start
        for (int k = 1; k <= 300 && tail < 6; k++) begin
            @(negedge clock);
            bus_if.start = 1'b0;
            bus_if.abort = 1'b0;
            if (bus_if.rd_en) begin
                rd_q.push_back(bus_if.rd_addr);
                rk_q.push_back(k);
                if (n_done > 0) rd_after++;
            end
            if (bus_if.wr_en) begin
                wa_q.push_back(bus_if.wr_addr);
                wd_q.push_back(bus_if.wr_data);
                wk_q.push_back(k);
            end
            if (bus_if.busy) busy_hi++;
            if (n_done > 0) begin
                tail++;
                if (bus_if.busy) busy_after++;
            end
            if (bus_if.done) begin
                n_done++;
                done_k     = k;
                ab_at_done = bus_if.aborted;
                if (restart) bus_if.start = 1'b1;
            end
            if (abort_at > 0 && bus_if.rd_en && rd_q.size() == abort_at) bus_if.abort = 1'b1;
        end
    endtask

    task automatic verify_dense(input string tag, input logic [15:0] base, input logic [15:0] stride,
                                input logic [9:0] dst, input int len, input int n);
        logic [15:0] ea;
        logic [9:0]  ew;
        check_val({tag, "_rd_cnt"}, rd_q.size(), n);
        check_val({tag, "_wr_cnt"}, wa_q.size(), n);
        for (int i = 0; i < n && i < rd_q.size() && i < wa_q.size(); i++) begin
            ea = base + 16'(i / len) * stride + 16'(i % len);
            ew = dst + 10'(i);
            check_val($sformatf("%s_rd_addr%0d", tag, i), rd_q[i], ea);
            check_val($sformatf("%s_rd_slot%0d", tag, i), rk_q[i], i + 1);
            check_val($sformatf("%s_wr_addr%0d", tag, i), wa_q[i], ew);
            check_val($sformatf("%s_wr_data%0d", tag, i), wd_q[i], data_of(ea));
            check_val($sformatf("%s_wr_slot%0d", tag, i), wk_q[i], i + 3);
        end
    endtask

    initial begin
        int cnt;
        bus_if.start = 0; bus_if.abort = 0;
        bus_if.src_base = 0; bus_if.src_stride = 0; bus_if.dst_base = 0;
        bus_if.length = 0; bus_if.height = 0; bus_if.pad = 0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_val("rst_busy",    bus_if.busy,    0);
        check_val("rst_done",    bus_if.done,    0);
        check_val("rst_aborted", bus_if.aborted, 0);
        check_val("rst_rd_en",   bus_if.rd_en,   0);
        check_val("rst_wr_en",   bus_if.wr_en,   0);
        check_val("rst_rd_addr", bus_if.rd_addr, 0);
        check_val("rst_wr_addr", bus_if.wr_addr, 0);
        rst_n = 1'b1;

        // 4x3 tile, 15 cycles: 12 issue, 2 drain, done
        run_xfer(16'h0100, 16'd16, 10'h020, 6'd4, 6'd3, 2'd0, 0, 1'b0);
        verify_dense("t1", 16'h0100, 16'd16, 10'h020, 4, 12);
        check_val("t1_done_cnt",  n_done, 1);
        check_val("t1_done_k",    done_k, 15);
        check_val("t1_aborted",   ab_at_done, 0);
        check_val("t1_busy_cyc",  busy_hi, 14);
        check_val("t1_busy_post", busy_after, 0);

        // empty tile: done right after start is sampled
        run_xfer(16'h0100, 16'd16, 10'h020, 6'd0, 6'd5, 2'd0, 0, 1'b0);
        check_val("t2_rd_cnt",   rd_q.size(), 0);
        check_val("t2_wr_cnt",   wa_q.size(), 0);
        check_val("t2_done_cnt", n_done, 1);
        check_val("t2_done_k",   done_k, 1);
        check_val("t2_busy_cyc", busy_hi, 0);

        // address wrap on both ports
        run_xfer(16'hFFFE, 16'd16, 10'h3FE, 6'd4, 6'd1, 2'd0, 0, 1'b0);
        verify_dense("t3", 16'hFFFE, 16'd16, 10'h3FE, 4, 4);
        check_val("t3_rd_last", rd_q.size() == 4 ? rd_q[3] : 16'hDEAD, 16'h0001);
        check_val("t3_wr_last", wa_q.size() == 4 ? wa_q[3] : 10'h155, 10'h001);

        // abort on 10th read, start during done must be ignored
        run_xfer(16'h0200, 16'd8, 10'h040, 6'd8, 6'd8, 2'd0, 10, 1'b1);
        verify_dense("t4", 16'h0200, 16'd8, 10'h040, 8, 10);
        check_val("t4_done_cnt",  n_done, 1);
        check_val("t4_done_k",    done_k, 13);
        check_val("t4_aborted",   ab_at_done, 1);
        check_val("t4_rd_post",   rd_after, 0);
        check_val("t4_busy_post", busy_after, 0);

        // reset in the middle of ISSUE
        @(negedge clock);
        bus_if.src_base = 16'h0400; bus_if.src_stride = 16'd8; bus_if.dst_base = 10'h010;
        bus_if.length = 6'd8; bus_if.height = 6'd8; bus_if.pad = 2'd0; bus_if.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus_if.start = 1'b0;
        repeat (4) @(negedge clock);
        check_val("t5_busy_pre", bus_if.busy, 1);
        rst_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_val("t5_busy",    bus_if.busy,    0);
        check_val("t5_done",    bus_if.done,    0);
        check_val("t5_aborted", bus_if.aborted, 0);
        check_val("t5_rd_en",   bus_if.rd_en,   0);
        check_val("t5_wr_en",   bus_if.wr_en,   0);
        check_val("t5_rd_addr", bus_if.rd_addr, 0);
        check_val("t5_wr_addr", bus_if.wr_addr, 0);
        rst_n = 1'b1;
        cnt = 0;
        repeat (12) begin
            @(negedge clock);
            if (bus_if.wr_en || bus_if.rd_en) cnt++;
        end
        check_val("t5_quiet", cnt, 0);
        run_xfer(16'h0100, 16'd16, 10'h020, 6'd4, 6'd3, 2'd0, 0, 1'b0);
        verify_dense("t5r", 16'h0100, 16'd16, 10'h020, 4, 12);
        check_val("t5r_done_k", done_k, 15);

`ifdef GLB2LB_PAD_EN
        // 2x2 interior, 1-wide border: 4x4 output, 16 slots, done at 19
        run_xfer(16'h0300, 16'd16, 10'h080, 6'd2, 6'd2, 2'd1, 0, 1'b0);
        check_val("t6_rd_cnt",   rd_q.size(), 4);
        check_val("t6_wr_cnt",   wa_q.size(), 16);
        check_val("t6_done_k",   done_k, 19);
        for (int i = 0; i < 16 && i < wa_q.size(); i++) begin
            int r, c;
            logic [127:0] ed;
            r  = i / 4;
            c  = i % 4;
            ed = (r >= 1 && r <= 2 && c >= 1 && c <= 2)
                 ? data_of(16'h0300 + 16'((r - 1) * 16 + (c - 1))) : 128'h0;
            check_val($sformatf("t6_wr_addr%0d", i), wa_q[i], 10'h080 + 10'(i));
            check_val($sformatf("t6_wr_data%0d", i), wd_q[i], ed);
            check_val($sformatf("t6_wr_slot%0d", i), wk_q[i], i + 3);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
